// File: rtl/sbox_sched.sv
// sbox_sched: shares one single-port S-box ROM between the round datapath
// (16-byte SubBytes/InvSubBytes) and the key expander (4-byte SubWord).
// Each accepted request streams one byte per cycle through the ROM. The
// assembled result is returned with a one-cycle done pulse.
module sbox_sched #(
    parameter int ST_BYTES  = 16,
    parameter int KW_BYTES  = 4,
    parameter int PRIO_MODE = 0
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  st_req,
    input  logic                  st_inv,
    input  logic [8*ST_BYTES-1:0] st_data,
    output logic                  st_ack,
    output logic                  st_done,
    output logic [8*ST_BYTES-1:0] st_result,
    input  logic                  kw_req,
    input  logic [8*KW_BYTES-1:0] kw_data,
    output logic                  kw_ack,
    output logic                  kw_done,
    output logic [8*KW_BYTES-1:0] kw_result,
    output logic [7:0]            rom_add,
    output logic                  rom_en,
    output logic                  rom_inv,
    input  logic [7:0]            rom_dout,
    output logic                  busy
);

    localparam int ST_W      = 8 * ST_BYTES;
    localparam int KW_W      = 8 * KW_BYTES;
    localparam int MAX_BYTES = (ST_BYTES > KW_BYTES) ? ST_BYTES : KW_BYTES;
    localparam int OP_W      = 8 * MAX_BYTES;
    localparam int CNT_W     = $clog2(MAX_BYTES + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    typedef enum logic {
        OWN_ST,
        OWN_KW
    } owner_t;

    state_t            state;
    owner_t            owner;
    owner_t            last_grant;
    logic [OP_W-1:0]   op_reg;
    logic              inv_reg;
    logic [CNT_W-1:0]  cnt;
    logic [CNT_W-1:0]  n_last;
    logic [CNT_W-1:0]  cap_idx;
    logic [OP_W-1:0]   st_aligned;
    logic [OP_W-1:0]   kw_aligned;

    // The result byte captured in step cnt belongs to the address issued in step cnt-1.
    assign cap_idx = cnt - CNT_W'(1);
    assign busy    = (state != S_IDLE);

    // Left-align both operands so byte k always sits at the same position in op_reg.
    always_comb begin
        // NOTE: every variable written here gets a default first so no latch is inferred.
        st_aligned = '0;
        kw_aligned = '0;
        st_aligned[OP_W-1 -: ST_W] = st_data;
        kw_aligned[OP_W-1 -: KW_W] = kw_data;
    end

    // Arbitration: ack only while idle and out of reset; a tie goes by PRIO_MODE.
    always_comb begin
        st_ack = 1'b0;
        kw_ack = 1'b0;
        if (state == S_IDLE && !reset) begin
            if (st_req && kw_req) begin
                if (PRIO_MODE == 1 || last_grant == OWN_ST) begin
                    kw_ack = 1'b1;
                end else begin
                    st_ack = 1'b1;
                end
            end else if (st_req) begin
                st_ack = 1'b1;
            end else if (kw_req) begin
                kw_ack = 1'b1;
            end
        end
    end

    // ROM drive: address byte cnt for steps 0..N-1; the last step only drains the read.
    always_comb begin
        rom_add = '0;
        rom_en  = 1'b0;
        rom_inv = 1'b0;
        if (state == S_RUN) begin
            rom_inv = inv_reg;
            if (cnt != n_last) begin
                rom_en = 1'b1;
                for (int i = 0; i < MAX_BYTES; i++) begin
                    if (cnt == CNT_W'(i)) begin
                        rom_add = op_reg[OP_W-1-8*i -: 8];
                    end
                end
            end
        end
    end

    // Control FSM with operand latch, byte-wise result capture and registered done pulses.
    always_ff @(posedge clock) begin
        if (reset) begin
            // NOTE: the result registers are ordinary flops, not a memory, so they are cleared here too.
            state      <= S_IDLE;
            owner      <= OWN_ST;
            last_grant <= OWN_ST;
            op_reg     <= '0;
            inv_reg    <= 1'b0;
            cnt        <= '0;
            n_last     <= '0;
            st_done    <= 1'b0;
            kw_done    <= 1'b0;
            st_result  <= '0;
            kw_result  <= '0;
        end else begin
            // NOTE: non-blocking assignments only, so every register updates together at the edge.
            st_done <= 1'b0;
            kw_done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (st_ack || kw_ack) begin
                        state      <= S_RUN;
                        cnt        <= '0;
                        owner      <= kw_ack ? OWN_KW : OWN_ST;
                        last_grant <= kw_ack ? OWN_KW : OWN_ST;
                        op_reg     <= kw_ack ? kw_aligned : st_aligned;
                        inv_reg    <= st_ack & st_inv;
                        n_last     <= kw_ack ? CNT_W'(KW_BYTES) : CNT_W'(ST_BYTES);
                    end
                end
                S_RUN: begin
                    if (cnt != '0) begin
                        if (owner == OWN_ST) begin
                            for (int i = 0; i < ST_BYTES; i++) begin
                                if (cap_idx == CNT_W'(i)) begin
                                    st_result[ST_W-1-8*i -: 8] <= rom_dout;
                                end
                            end
                        end else begin
                            for (int i = 0; i < KW_BYTES; i++) begin
                                if (cap_idx == CNT_W'(i)) begin
                                    kw_result[KW_W-1-8*i -: 8] <= rom_dout;
                                end
                            end
                        end
                    end
                    if (cnt == n_last) begin
                        state <= S_DONE;
                        if (owner == OWN_ST) begin
                            st_done <= 1'b1;
                        end else begin
                            kw_done <= 1'b1;
                        end
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                S_DONE: begin
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
